// File: rtl/itof_seq.sv
// Sequential 32-bit signed integer to IEEE-754 binary32 converter.
// One request in flight: IDLE -> NORM -> ROUND -> DONE, round-to-nearest-even.
module itof_seq (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] s,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] d
);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  state_t      state, state_next;
  logic [31:0] op;
  logic [31:0] norm;
  logic [5:0]  lz;
  logic        sign;

  logic [31:0] mag;
  logic [31:0] shifted;
  logic [5:0]  lz_c;
  logic        inc;
  logic [23:0] mant_sum;
  logic [7:0]  exp_c;
  logic [31:0] result;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = NORM;
      end
      NORM:  state_next = ROUND;
      ROUND: state_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Two's-complement negate leaves 0x80000000 unchanged, which is its correct magnitude.
  always_comb begin
    mag  = op[31] ? (~op + 32'd1) : op;
    lz_c = 6'd32;
    for (int unsigned i = 0; i < 32; i++) begin
      if (mag[i]) lz_c = 6'(31 - i);
    end
    shifted = mag << lz_c;
  end

  // After normalisation the MSB is clear only for a zero operand.
  always_comb begin
    inc      = norm[7] && ((|norm[6:0]) || norm[8]);
    mant_sum = {1'b0, norm[30:8]} + {23'd0, inc};
    exp_c    = 8'd158 - {2'b00, lz};
    if (mant_sum[23]) exp_c = exp_c + 8'd1;
    if (norm[31]) result = {sign, exp_c, mant_sum[22:0]};
    else          result = '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      op   <= '0;
      norm <= '0;
      lz   <= '0;
      sign <= 1'b0;
      d    <= '0;
    end else begin
      case (state)
        IDLE:  if (in_valid) op <= s;
        NORM: begin
          sign <= op[31];
          norm <= shifted;
          lz   <= lz_c;
        end
        ROUND: d <= result;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_itof_seq.sv
// Self-checking bench for itof_seq: directed corner cases, random operands,
// backpressure and mid-flight reset, against an arithmetic reference model.
module tb_itof_seq;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] s = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] d;

  int total = 0;
  int bad   = 0;

  itof_seq dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .s         (s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d)
  );

  always #5 clk = ~clk;

  // Reference: exact integer magnitude, find binade, round quotient by remainder.
  function automatic logic [31:0] model(input logic [31:0] v);
    longint m, q, rem, half;
    int e;
    logic sg;
    sg = v[31];
    m  = sg ? -longint'($signed(v)) : longint'(v);
    if (m == 0) return 32'h0;
    e = 0;
    while ((m >> (e + 1)) != 0) e++;
    if (e <= 23) begin
      q = m << (23 - e);
    end else begin
      q    = m >> (e - 23);
      rem  = m - (q << (e - 23));
      half = longint'(1) << (e - 24);
      if (rem > half || (rem == half && q[0])) q++;
      if (q == (longint'(1) << 24)) begin
        q = q >> 1;
        e++;
      end
    end
    return {sg, 8'(e + 127), q[22:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // hold > 0: out_ready low for that many DONE cycles with in_valid kept high.
  task automatic conv(input logic [31:0] val, input int hold);
    logic [31:0] exp_d;
    int cnt;
    exp_d = model(val);
    @(negedge clk);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    s         = val;
    out_ready = (hold == 0);
    @(negedge clk);
    cnt = 1;
    if (hold == 0) in_valid = 1'b0;
    s = $urandom;
    while (!out_valid && cnt < 12) begin
      @(negedge clk);
      cnt++;
      s = $urandom;
    end
    check("latency", 32'(cnt), 32'd3);
    check("result", d, exp_d);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      s = $urandom;
      check("hold_d", d, exp_d);
      check("hold_busy", {30'd0, in_ready, out_valid}, 32'b01);
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("after_consume", {30'd0, in_ready, out_valid}, 32'b10);
    check("d_retained", d, exp_d);
  endtask

  logic [31:0] directed [10] = '{
    32'h00000001, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 32'h7FFFFFFF,
    32'h01000001, 32'h01000003, 32'h01000005, 32'h00FFFFFF, 32'hFEFFFFFF
  };
  logic [31:0] spec_exp [8] = '{
    32'h3F800000, 32'hBF800000, 32'h00000000, 32'hCF000000, 32'h4F000000,
    32'h4B800000, 32'h4B800002, 32'h4B800002
  };

  initial begin
    logic [31:0] r;
    #1;
    check("reset_ready", 32'(in_ready), 32'd1);
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_d", d, 32'h0);
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 8; i++) check("model_anchor", model(directed[i]), spec_exp[i]);
    for (int i = 0; i < 10; i++) conv(directed[i], 0);

    conv(32'h12345678, 5);

    for (int i = 0; i < 150; i++) begin
      r = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) r = ~r + 32'd1;
      conv(r, (i % 17 == 0) ? 2 : 0);
    end

    // Abort a request while it is in ROUND.
    conv(32'h00000007, 0);
    @(negedge clk);
    in_valid = 1'b1;
    s        = 32'h0000ABCD;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check("rst_mid_valid", 32'(out_valid), 32'd0);
    check("rst_mid_ready", 32'(in_ready), 32'd1);
    check("rst_mid_d", d, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("no_stale_valid", 32'(out_valid), 32'd0);
      check("no_stale_d", d, 32'h0);
    end
    conv(32'hFFFFFF00, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
